// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared tile map geometry, writer FSM encoding and request entry type.
package vga_pkg;

   localparam int VGA_ADDR_W = 16;
   localparam int VGA_DATA_W = 16;
   localparam int MAP_BASE   = 1;
   localparam int MAP_COLS   = 20;
   localparam int MAP_ROWS   = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FILL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [VGA_ADDR_W-1:0] addr;
      logic [VGA_DATA_W-1:0] data;
   } req_entry_t;

endpackage

// File: rtl/vga_req_fifo.sv
// rtl/vga_req_fifo.sv - synchronous request FIFO with occupancy count, async active-high reset.
module vga_req_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign do_push  = push && (count != FULL_COUNT);
   assign do_pop   = pop && !empty;
   assign pop_data = store[rd_ptr];

   // Storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/vga_tilemap_writer.sv
// rtl/vga_tilemap_writer.sv - CPU-side tile map writer: (x,y) requests and whole-map fill,
// committed to the RAM write port only while the display is blanked.
module vga_tilemap_writer #(
   parameter int ADDR_W     = vga_pkg::VGA_ADDR_W,
   parameter int DATA_W     = vga_pkg::VGA_DATA_W,
   parameter int MAP_BASE   = vga_pkg::MAP_BASE,
   parameter int MAP_COLS   = vga_pkg::MAP_COLS,
   parameter int MAP_ROWS   = vga_pkg::MAP_ROWS,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [4:0]                  req_x,
   input  logic [3:0]                  req_y,
   input  logic [DATA_W-1:0]           req_tile,
   input  logic                        fill_start,
   input  logic [DATA_W-1:0]           fill_tile,
   output logic                        fill_busy,
   input  logic                        vblank,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_din,
   output logic                        err_range,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   import vga_pkg::state_t;
   import vga_pkg::IDLE;
   import vga_pkg::DRAIN;
   import vga_pkg::FILL;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] FILL_FIRST = ADDR_W'(MAP_BASE);
   localparam logic [ADDR_W-1:0] FILL_LAST  = ADDR_W'(MAP_BASE + MAP_COLS * MAP_ROWS - 1);

   state_t              state;
   state_t              state_nx;
   logic                hs;
   logic                in_range;
   logic                push;
   logic                pop;
   logic                fifo_empty;
   logic [ADDR_W-1:0]   req_addr;
   logic [ENT_W-1:0]    push_entry;
   logic [ENT_W-1:0]    pop_entry;
   logic                fill_go;
   logic                fill_pend;
   logic                fill_enter;
   logic                fill_step;
   logic [ADDR_W-1:0]   fill_addr;
   logic [DATA_W-1:0]   fill_value;
   logic                we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   din_d;

   assign req_ready  = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign hs         = req_valid && req_ready;
   assign in_range   = (int'(req_x) < MAP_COLS) && (int'(req_y) < MAP_ROWS);
   assign push       = hs && in_range;
   assign req_addr   = ADDR_W'(MAP_BASE + int'(req_y) * MAP_COLS + int'(req_x));
   assign push_entry = {req_addr, req_tile};

   // fill_busy lags the state by one cycle, so both must be checked to ignore a restart.
   assign fill_go    = fill_start && !fill_busy && (state != FILL);
   assign fill_enter = (state == IDLE) && (state_nx == FILL);

   vga_req_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (pop_entry),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (fill_go || fill_pend)        state_nx = FILL;
            else if (vblank && !fifo_empty)  state_nx = DRAIN;
         end
         DRAIN: if (!vblank || fifo_empty)   state_nx = IDLE;
         FILL:  if (vblank && fill_addr == FILL_LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // IDLE pops directly so a single request lands one cycle after acceptance.
   always_comb begin
      pop       = 1'b0;
      fill_step = 1'b0;
      we_d      = 1'b0;
      addr_d    = mem_addr;
      din_d     = mem_din;
      case (state)
         IDLE:  pop = !(fill_go || fill_pend) && vblank && !fifo_empty;
         DRAIN: pop = vblank && !fifo_empty;
         FILL: begin
            if (vblank) begin
               fill_step = 1'b1;
               we_d      = 1'b1;
               addr_d    = fill_addr;
               din_d     = fill_value;
            end
         end
         default: pop = 1'b0;
      endcase
      if (pop) begin
         we_d   = 1'b1;
         addr_d = pop_entry[ENT_W-1 -: ADDR_W];
         din_d  = pop_entry[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         err_range  <= 1'b0;
         fill_busy  <= 1'b0;
         fill_pend  <= 1'b0;
         fill_addr  <= '0;
         fill_value <= '0;
      end else begin
         mem_we    <= we_d;
         mem_addr  <= addr_d;
         mem_din   <= din_d;
         err_range <= hs && !in_range;
         fill_busy <= (state == FILL);
         if (fill_go) begin
            fill_value <= fill_tile;
            if (state == DRAIN) fill_pend <= 1'b1;
         end
         if (fill_enter) begin
            fill_addr <= FILL_FIRST;
            fill_pend <= 1'b0;
         end else if (fill_step) begin
            fill_addr <= fill_addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_tilemap_writer.sv
// tb/tb_vga_tilemap_writer.sv - scoreboard bench: expected RAM write stream vs observed mem_we traffic.
module tb_vga_tilemap_writer;
   import vga_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_x;
   logic [3:0]  req_y;
   logic [15:0] req_tile;
   logic        fill_start;
   logic [15:0] fill_tile;
   logic        fill_busy;
   logic        vblank;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        err_range;
   logic [3:0]  fifo_count;

   int total = 0;
   int bad = 0;
   int exp_err = 0;
   int err_seen = 0;
   int busy_cycles = 0;
   int writes = 0;
   req_entry_t exp_q[$];

   vga_tilemap_writer dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_tile(req_tile),
      .fill_start(fill_start), .fill_tile(fill_tile), .fill_busy(fill_busy),
      .vblank(vblank), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .err_range(err_range), .fifo_count(fifo_count)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic monitor();
      req_entry_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fill_busy) busy_cycles++;
            if (err_range) err_seen++;
            if (mem_we) begin
               writes++;
               check("write_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("wr_addr", 32'(mem_addr), 32'(e.addr));
                  check("wr_data", 32'(mem_din), 32'(e.data));
               end
            end
         end
      end
   endtask

   // Reference: a map write lands at 1 + y*20 + x; out-of-range requests produce no write.
   task automatic send(input int x, input int y, input logic [15:0] tile);
      req_entry_t e;
      int guard = 0;
      req_x = 5'(x);
      req_y = 4'(y);
      req_tile = tile;
      req_valid = 1'b1;
      while (!req_ready && guard < 200) begin
         vblank = 1'b1;
         tick();
         guard++;
      end
      check("send_ready", 32'(req_ready), 1);
      if (x < 20 && y < 15) begin
         e.addr = 16'(1 + y * 20 + x);
         e.data = tile;
         exp_q.push_back(e);
      end else begin
         exp_err++;
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic start_fill(input logic [15:0] tile, input bit expect_run);
      req_entry_t e;
      fill_tile = tile;
      fill_start = 1'b1;
      if (expect_run) begin
         for (int a = 1; a <= 300; a++) begin
            e.addr = 16'(a);
            e.data = tile;
            exp_q.push_back(e);
         end
      end
      tick();
      fill_start = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((exp_q.size() != 0 || fill_busy) && guard < 2000) begin
         tick();
         guard++;
      end
      check("drain_complete", 32'(exp_q.size()), 0);
   endtask

   task automatic wait_write_at(input int addr);
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(mem_we && int'(mem_addr) == addr) && guard < 1000);
      check("fill_reached_addr", 32'(mem_addr), 32'(addr));
   endtask

   initial begin
      int found;
      int run;
      int paused;
      int w0;
      logic [15:0] seen_addr;
      logic [15:0] seen_din;
      rst = 1'b1;
      req_valid = 1'b0;
      req_x = '0;
      req_y = '0;
      req_tile = '0;
      fill_start = 1'b0;
      fill_tile = '0;
      vblank = 1'b0;
      fork
         monitor();
      join_none

      #5;
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_din", 32'(mem_din), 0);
      check("rst_fill_busy", 32'(fill_busy), 0);
      check("rst_err_range", 32'(err_range), 0);
      check("rst_fifo_count", 32'(fifo_count), 0);
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(req_ready), 1);

      // single write latency
      vblank = 1'b1;
      tick();
      send(3, 2, 16'h0041);
      found = 0;
      seen_addr = '0;
      seen_din = '0;
      for (int k = 0; k < 2 && found == 0; k++) begin
         @(negedge clk);
         if (mem_we) begin
            found = 1;
            seen_addr = mem_addr;
            seen_din = mem_din;
         end
      end
      check("single_write_seen", 32'(found), 1);
      check("single_write_addr", 32'(seen_addr), 44);
      check("single_write_data", 32'(seen_din), 32'h41);
      wait_idle();

      // fill FIFO while blanking is off
      vblank = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) send(i, i, 16'(16'h100 + i));
      check("full_ready_low", 32'(req_ready), 0);
      check("full_count", 32'(fifo_count), 8);
      req_valid = 1'b1;
      req_x = 5'd9;
      req_y = 4'd9;
      repeat (3) tick();
      check("full_no_push", 32'(fifo_count), 8);
      req_valid = 1'b0;
      vblank = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge clk);
         if (mem_we) found = 1;
      end
      run = found;
      while (found != 0 && run < 20) begin
         @(negedge clk);
         if (mem_we) run++;
         else found = 0;
      end
      check("drain_burst_len", 32'(run), 8);
      check("drain_count_zero", 32'(fifo_count), 0);
      wait_idle();

      // full fill with ignored restart
      tick();
      busy_cycles = 0;
      start_fill(16'h0007, 1'b1);
      repeat (50) tick();
      start_fill(16'h0099, 1'b0);
      wait_idle();
      check("fill_busy_cycles", 32'(busy_cycles), 300);

      // fill with blanking pause and a request queued mid-fill
      start_fill(16'($urandom), 1'b1);
      wait_write_at(99);
      tick();
      vblank = 1'b0;
      @(negedge clk);
      paused = 0;
      repeat (9) begin
         @(negedge clk);
         if (mem_we) paused++;
      end
      check("pause_no_writes", 32'(paused), 0);
      tick();
      send($urandom_range(0, 19), $urandom_range(0, 14), 16'($urandom));
      vblank = 1'b1;
      wait_idle();

      // out-of-range requests
      send(20, 0, 16'h1111);
      send(0, 15, 16'h2222);
      repeat (3) tick();
      check("err_pulses", 32'(err_seen), 32'(exp_err));
      check("err_no_queue", 32'(fifo_count), 0);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         vblank = ($urandom_range(0, 3) != 0);
         send($urandom_range(0, 23), $urandom_range(0, 15), 16'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      vblank = 1'b1;
      wait_idle();
      repeat (2) tick();
      check("err_total", 32'(err_seen), 32'(exp_err));

      // reset in the middle of a fill
      start_fill(16'($urandom), 1'b1);
      send(5, 5, 16'h1234);
      wait_write_at(150);
      tick();
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_mem_we", 32'(mem_we), 0);
      check("midrst_fill_busy", 32'(fill_busy), 0);
      check("midrst_fifo_count", 32'(fifo_count), 0);
      repeat (3) tick();
      rst = 1'b0;
      w0 = writes;
      repeat (30) tick();
      check("postrst_no_writes", 32'(writes), 32'(w0));
      check("postrst_fill_busy", 32'(fill_busy), 0);
      check("postrst_ready", 32'(req_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_tilemap_writer.md
Name: vga_tilemap_writer

Overview:
- CPU-side writer for the VGA tile map held in the main block RAM. The VGA read path fetches superpixel tile numbers from this same map.
- Accepts tile-write requests addressed by superpixel (x, y) and converts each to a linear RAM address.
- Buffers requests in a small FIFO and commits them to the RAM write port only while the display is blanked, so scan-out never reads a half-updated map.
- Also supports a whole-screen fill command.

Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width / tile word width
- MAP_BASE, 1, RAM address of tile (0,0)
- MAP_COLS, 20, superpixel columns
- MAP_ROWS, 15, superpixel rows
- FIFO_DEPTH, 8, request FIFO entries (power of two)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  tile write request
- req_ready  out  1  request accepted when high with req_valid
- req_x  in  5  superpixel column
- req_y  in  4  superpixel row
- req_tile  in  DATA_W  tile number to store
- fill_start  in  1  single-cycle pulse: fill the whole map
- fill_tile  in  DATA_W  tile value for fill, sampled on fill_start
- fill_busy  out  1  fill in progress
- vblank  in  1  high while RAM writes are permitted (blanking interval)
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM write address
- mem_din  out  DATA_W  RAM write data
- err_range  out  1  one-cycle pulse: request dropped because it was out of range
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high. All state is cleared on rst assertion, independent of clk.
- Reset values: req_ready=0 while rst is high, then 1 on the first cycle after release (FIFO empty). All other outputs are 0: fill_busy, mem_we, mem_addr, mem_din, err_range, fifo_count.
- Enqueue:
  - A handshake occurs when req_valid && req_ready on a clk edge.
  - Address = MAP_BASE + req_y*MAP_COLS + req_x, computed at enqueue and truncated to ADDR_W.
  - If req_x >= MAP_COLS or req_y >= MAP_ROWS, the request is consumed but not stored, and err_range pulses the next cycle.
  - req_ready = (fifo_count < FIFO_DEPTH), derived from registered count. There is no pass-through when full.
  - Enqueue is allowed in every state, including during a fill.
- FSM states: IDLE, DRAIN, FILL.
  - IDLE -> FILL on fill_start. fill_start has priority over draining in the same cycle.
  - IDLE -> DRAIN when vblank=1 and FIFO is non-empty.
  - DRAIN: pops one entry per cycle while vblank=1. mem_we=1, with mem_addr/mem_din registered from the popped entry in the same cycle.
  - DRAIN -> IDLE when FIFO is empty or vblank=0. The entry in flight on that edge still completes; no partial writes.
  - fill_start arriving in DRAIN is held pending. FILL is entered after DRAIN returns to IDLE.
  - FILL:
    - fill_busy=1.
    - An internal counter walks MAP_BASE .. MAP_BASE+MAP_COLS*MAP_ROWS-1, writing fill_tile once per cycle while vblank=1.
    - When vblank=0 the counter holds and mem_we=0, then resumes at the same address.
    - After the last address: FILL -> IDLE, and fill_busy drops the cycle after the final write.
  - fill_start while fill_busy=1 is ignored; the counter does not restart.
- Ordering: queued writes accepted before or during a fill drain only after the fill completes. Later writes therefore overwrite fill data.
- Simultaneous push and pop: fifo_count stays unchanged. A push when full is impossible (req_ready=0).
- Reset mid-fill or mid-drain: everything aborts immediately. FIFO contents are discarded and mem_we drops asynchronously.
- Write latency: an entry accepted at edge N is written no earlier than edge N+1, provided vblank=1 and the state is IDLE.

Decomposition:
- Shared package vga_pkg holds:
  - MAP_COLS and MAP_ROWS (20, 15)
  - MAP_BASE
  - FSM state encoding {IDLE, DRAIN, FILL}
  - the request entry struct {addr[ADDR_W], data[DATA_W]}
- One sub-module: vga_req_fifo, a synchronous FIFO with count output and asynchronous reset, parameterized by width and depth.
- Address computation and the FSM stay in the top module.

Test Plan:
- Hold vblank=1; send (x=3, y=2, tile=0x0041) -> one write with mem_addr=44 (1+2*20+3), mem_din=0x0041, within 2 cycles.
- Hold vblank=0; push 9 requests back-to-back -> req_ready drops after the 8th and fifo_count=8. Raise vblank -> 8 consecutive mem_we cycles in push order, then fifo_count=0.
- fill_start with fill_tile=0x0007, vblank=1 -> 300 consecutive writes to addresses 1..300, value 7. fill_busy is high for 300 cycles, and a second fill_start mid-fill has no effect.
- During a fill, toggle vblank low for 10 cycles at address 100 -> writes pause, then resume at 100 with no skipped or duplicated address. A request queued mid-fill is written after address 300.
- Send (x=20, y=0) and (x=0, y=15) -> both accepted, no mem_we, err_range pulses once for each.
- Assert rst mid-fill at address 150 -> mem_we=0 immediately, fill_busy=0, fifo_count=0. After release, no further writes occur without a new request.
